// File: rtl/mem_ctrl_pkg.sv
// Shared memory-controller types: DIMM command encodings, bank-table entry and
// scheduler state, plus a saturating counter helper.
package mem_ctrl_pkg;

    localparam int MAX_ROW_BITS = 32;

    typedef enum logic [2:0] {
        CMD_READ      = 3'd0,
        CMD_WRITE     = 3'd1,
        CMD_ACTIVATE  = 3'd2,
        CMD_PRECHARGE = 3'd3,
        CMD_NOP       = 3'd7
    } cmd_t;

    typedef struct packed {
        logic                    open;
        logic [MAX_ROW_BITS-1:0] row;
    } bank_entry_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_WAIT_PRE,
        ST_ACT,
        ST_WAIT_ACT,
        ST_COL,
        ST_WAIT_COL
    } sched_state_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/bank_row_table.sv
// Open-row tracker: one {open,row} entry per bank, combinational lookup,
// single synchronous write port, cleared by reset.
module bank_row_table
    import mem_ctrl_pkg::*;
#(
    parameter int NUM_BANKS = 8,
    parameter int ROW_BITS  = 8,
    parameter int IDX_W     = $clog2(NUM_BANKS)
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic [IDX_W-1:0]    lookup_idx_in,
    input  logic [ROW_BITS-1:0] lookup_row_in,
    output logic                lookup_open_out,
    output logic                lookup_hit_out,
    input  logic                wr_en_in,
    input  logic                wr_open_in,
    input  logic [IDX_W-1:0]    wr_idx_in,
    input  logic [ROW_BITS-1:0] wr_row_in
);

    bank_entry_t table_w [NUM_BANKS];
    bank_entry_t sel;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BANKS; gi++) begin : g_entry
            bank_entry_t entry_q;
            bank_entry_t entry_d;

            always_comb begin
                entry_d = entry_q;
                if (wr_en_in && (wr_idx_in == IDX_W'(gi))) begin
                    entry_d.open = wr_open_in;
                    // Closing keeps the stale row; only the open bit matters then.
                    if (wr_open_in) begin
                        entry_d.row = MAX_ROW_BITS'(wr_row_in);
                    end
                end
            end

            always_ff @(posedge clk_in or posedge rst_in) begin
                if (rst_in) begin
                    entry_q <= '0;
                end else begin
                    entry_q <= entry_d;
                end
            end

            assign table_w[gi] = entry_q;
        end
    endgenerate

    assign sel             = table_w[lookup_idx_in];
    assign lookup_open_out = sel.open;
    assign lookup_hit_out  = sel.open && (sel.row == MAX_ROW_BITS'(lookup_row_in));

endmodule

// File: rtl/bank_cmd_scheduler.sv
// In-order, single-outstanding DRAM command scheduler with open-page policy:
// issues PRECHARGE/ACTIVATE/READ/WRITE with latency spacing enforced.
module bank_cmd_scheduler
    import mem_ctrl_pkg::*;
#(
    parameter int ROW_BITS           = 8,
    parameter int COL_BITS           = 4,
    parameter int PADDR_BITS         = 64,
    parameter int BANK_GROUPS        = 4,
    parameter int BANKS_PER_GROUP    = 2,
    parameter int ACTIVATION_LATENCY = 8,
    parameter int PRECHARGE_LATENCY  = 5,
    parameter int BURST_GAP          = 8
) (
    input  logic                               clk_in,
    input  logic                               rst_in,
    input  logic                               req_valid_in,
    output logic                               req_ready_out,
    input  logic [PADDR_BITS-1:0]              req_addr_in,
    input  logic                               req_write_in,
    input  logic [511:0]                       req_data_in,
    output logic                               cmd_valid_out,
    output logic [2:0]                         cmd_out,
    output logic [$clog2(BANK_GROUPS)-1:0]     bg_out,
    output logic [$clog2(BANKS_PER_GROUP)-1:0] ba_out,
    output logic [ROW_BITS-1:0]                row_out,
    output logic [COL_BITS-1:0]                col_out,
    output logic [511:0]                       wdata_out,
    output logic [31:0]                        row_hits_out,
    output logic [31:0]                        row_conflicts_out
);

    localparam int BG_W      = $clog2(BANK_GROUPS);
    localparam int BA_W      = $clog2(BANKS_PER_GROUP);
    localparam int NUM_BANKS = BANK_GROUPS * BANKS_PER_GROUP;
    localparam int BA_LSB    = COL_BITS;
    localparam int BG_LSB    = BA_LSB + BA_W;
    localparam int ROW_LSB   = BG_LSB + BG_W;
    localparam int ADDR_TOP  = ROW_LSB + ROW_BITS;
    localparam int MAX_LAT   = (ACTIVATION_LATENCY > PRECHARGE_LATENCY)
                             ? ((ACTIVATION_LATENCY > BURST_GAP) ? ACTIVATION_LATENCY : BURST_GAP)
                             : ((PRECHARGE_LATENCY > BURST_GAP) ? PRECHARGE_LATENCY : BURST_GAP);
    localparam int CNT_W     = $clog2(MAX_LAT) + 1;

    generate
        if (ACTIVATION_LATENCY < 1 || PRECHARGE_LATENCY < 1 || BURST_GAP < 1) begin : g_bad_latency
            $error("bank_cmd_scheduler: latency parameters must be at least 1");
        end
    endgenerate

    sched_state_t        state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ready_q, ready_d;
    logic                cmd_valid_q, cmd_valid_d;
    cmd_t                cmd_q, cmd_d;
    logic [BG_W-1:0]     bg_q, bg_d;
    logic [BA_W-1:0]     ba_q, ba_d;
    logic [ROW_BITS-1:0] row_q, row_d;
    logic [COL_BITS-1:0] col_q, col_d;
    logic                write_q, write_d;
    logic [511:0]        wdata_q, wdata_d;
    logic [31:0]         hits_q, hits_d;
    logic [31:0]         conflicts_q, conflicts_d;

    logic [BG_W-1:0]     addr_bg;
    logic [BA_W-1:0]     addr_ba;
    logic [ROW_BITS-1:0] addr_row;
    logic [COL_BITS-1:0] addr_col;
    logic                unused_addr_bits;
    logic                accept;
    logic                lookup_open, lookup_hit;
    logic                tbl_wr_en, tbl_wr_open;
    logic                issue;
    cmd_t                issue_cmd;

    assign addr_col         = req_addr_in[COL_BITS-1:0];
    assign addr_ba          = req_addr_in[BA_LSB +: BA_W];
    assign addr_bg          = req_addr_in[BG_LSB +: BG_W];
    assign addr_row         = req_addr_in[ROW_LSB +: ROW_BITS];
    assign unused_addr_bits = ^req_addr_in[PADDR_BITS-1:ADDR_TOP];
    assign accept           = req_valid_in && ready_q;

    bank_row_table #(
        .NUM_BANKS (NUM_BANKS),
        .ROW_BITS  (ROW_BITS)
    ) u_table (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .lookup_idx_in   ({addr_bg, addr_ba}),
        .lookup_row_in   (addr_row),
        .lookup_open_out (lookup_open),
        .lookup_hit_out  (lookup_hit),
        .wr_en_in        (tbl_wr_en),
        .wr_open_in      (tbl_wr_open),
        .wr_idx_in       ({bg_q, ba_q}),
        .wr_row_in       (row_q)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ready_d     = 1'b0;
        cmd_valid_d = 1'b0;
        cmd_d       = CMD_NOP;
        bg_d        = bg_q;
        ba_d        = ba_q;
        row_d       = row_q;
        col_d       = col_q;
        write_d     = write_q;
        wdata_d     = wdata_q;
        hits_d      = hits_q;
        conflicts_d = conflicts_q;
        tbl_wr_en   = 1'b0;
        tbl_wr_open = 1'b0;
        issue       = 1'b0;
        issue_cmd   = CMD_NOP;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    bg_d    = addr_bg;
                    ba_d    = addr_ba;
                    row_d   = addr_row;
                    col_d   = addr_col;
                    write_d = req_write_in;
                    if (req_write_in) begin
                        wdata_d = req_data_in;
                    end
                    issue = 1'b1;
                    if (lookup_hit) begin
                        issue_cmd = req_write_in ? CMD_WRITE : CMD_READ;
                        hits_d    = sat_inc(hits_q);
                    end else if (!lookup_open) begin
                        issue_cmd = CMD_ACTIVATE;
                    end else begin
                        issue_cmd   = CMD_PRECHARGE;
                        conflicts_d = sat_inc(conflicts_q);
                    end
                end else begin
                    ready_d = 1'b1;
                end
            end
            // The wait counter loads when a command issues, so the issue cycle
            // itself counts toward the spacing.
            ST_PRE, ST_WAIT_PRE: begin
                tbl_wr_en = (state_q == ST_PRE);
                if (cnt_q == '0) begin
                    issue     = 1'b1;
                    issue_cmd = CMD_ACTIVATE;
                end else begin
                    cnt_d   = cnt_q - CNT_W'(1);
                    state_d = ST_WAIT_PRE;
                end
            end
            ST_ACT, ST_WAIT_ACT: begin
                tbl_wr_en   = (state_q == ST_ACT);
                tbl_wr_open = 1'b1;
                if (cnt_q == '0) begin
                    issue     = 1'b1;
                    issue_cmd = write_q ? CMD_WRITE : CMD_READ;
                end else begin
                    cnt_d   = cnt_q - CNT_W'(1);
                    state_d = ST_WAIT_ACT;
                end
            end
            ST_COL, ST_WAIT_COL: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    ready_d = 1'b1;
                end else begin
                    cnt_d   = cnt_q - CNT_W'(1);
                    state_d = ST_WAIT_COL;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (issue) begin
            cmd_valid_d = 1'b1;
            cmd_d       = issue_cmd;
            case (issue_cmd)
                CMD_PRECHARGE: begin
                    state_d = ST_PRE;
                    cnt_d   = CNT_W'(PRECHARGE_LATENCY - 1);
                end
                CMD_ACTIVATE: begin
                    state_d = ST_ACT;
                    cnt_d   = CNT_W'(ACTIVATION_LATENCY - 1);
                end
                default: begin
                    state_d = ST_COL;
                    cnt_d   = CNT_W'(BURST_GAP - 1);
                end
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            ready_q     <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_q       <= CMD_NOP;
            bg_q        <= '0;
            ba_q        <= '0;
            row_q       <= '0;
            col_q       <= '0;
            write_q     <= 1'b0;
            wdata_q     <= '0;
            hits_q      <= '0;
            conflicts_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ready_q     <= ready_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_q       <= cmd_d;
            bg_q        <= bg_d;
            ba_q        <= ba_d;
            row_q       <= row_d;
            col_q       <= col_d;
            write_q     <= write_d;
            wdata_q     <= wdata_d;
            hits_q      <= hits_d;
            conflicts_q <= conflicts_d;
        end
    end

    assign req_ready_out     = ready_q;
    assign cmd_valid_out     = cmd_valid_q;
    assign cmd_out           = cmd_q;
    assign bg_out            = bg_q;
    assign ba_out            = ba_q;
    assign row_out           = row_q;
    assign col_out           = col_q;
    assign wdata_out         = wdata_q;
    assign row_hits_out      = hits_q;
    assign row_conflicts_out = conflicts_q;

endmodule

// File: tb/tb_bank_cmd_scheduler.sv
// Directed bench for bank_cmd_scheduler: vector table of requests with
// hand-computed command timing, plus hold-valid and mid-sequence reset cases.
module tb_bank_cmd_scheduler;

    logic         clk_in;
    logic         rst_in;
    logic         req_valid_in;
    logic         req_ready_out;
    logic [63:0]  req_addr_in;
    logic         req_write_in;
    logic [511:0] req_data_in;
    logic         cmd_valid_out;
    logic [2:0]   cmd_out;
    logic [1:0]   bg_out;
    logic [0:0]   ba_out;
    logic [7:0]   row_out;
    logic [3:0]   col_out;
    logic [511:0] wdata_out;
    logic [31:0]  row_hits_out;
    logic [31:0]  row_conflicts_out;

    int checks = 0;
    int errors = 0;

    bank_cmd_scheduler dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .req_valid_in      (req_valid_in),
        .req_ready_out     (req_ready_out),
        .req_addr_in       (req_addr_in),
        .req_write_in      (req_write_in),
        .req_data_in       (req_data_in),
        .cmd_valid_out     (cmd_valid_out),
        .cmd_out           (cmd_out),
        .bg_out            (bg_out),
        .ba_out            (ba_out),
        .row_out           (row_out),
        .col_out           (col_out),
        .wdata_out         (wdata_out),
        .row_hits_out      (row_hits_out),
        .row_conflicts_out (row_conflicts_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Cycle offsets are relative to the accept edge; 0 means "not issued".
    typedef struct {
        logic [63:0] addr;
        logic        write;
        logic [63:0] seed;
        logic [1:0]  bg;
        logic        ba;
        logic [7:0]  row;
        logic [3:0]  col;
        int          pre_k;
        int          act_k;
        int          col_k;
        int          rdy_k;
        int          hits;
        int          conf;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [511:0] make_data(input logic [63:0] seed);
        logic [511:0] d;
        for (int b = 0; b < 8; b++) d[b*64 +: 64] = seed * 64'(b);
        return d;
    endfunction

    task automatic run_req(input vec_t v, input bit hold);
        int k;
        int pre_k, act_k, col_k, rdy_k, ncmd, nop_bad, fld_bad, wd_bad;
        logic [2:0]   col_cmd;
        logic [511:0] wd;
        bit           wd_seen;
        pre_k = 0; act_k = 0; col_k = 0; rdy_k = 0; ncmd = 0;
        nop_bad = 0; fld_bad = 0; wd_bad = 0; col_cmd = 3'd7; wd = '0; wd_seen = 0;

        k = 0;
        while (!req_ready_out && k < 100) begin
            @(negedge clk_in);
            k++;
        end
        chk("ready_before_req", 64'(req_ready_out), 64'd1);

        req_valid_in = 1'b1;
        req_addr_in  = v.addr;
        req_write_in = v.write;
        req_data_in  = make_data(v.seed);
        @(posedge clk_in);
        #1;
        if (!hold) begin
            req_valid_in = 1'b0;
        end
        req_addr_in  = 64'hDEAD_BEEF_0000_0BAD;
        req_write_in = ~v.write;
        req_data_in  = '1;

        for (int c = 1; c <= 40; c++) begin
            @(negedge clk_in);
            if (cmd_valid_out) begin
                ncmd++;
                case (cmd_out)
                    3'd3: pre_k = c;
                    3'd2: act_k = c;
                    3'd0, 3'd1: begin
                        col_k   = c;
                        col_cmd = cmd_out;
                        wd      = wdata_out;
                        wd_seen = 1;
                    end
                    default: nop_bad++;
                endcase
            end else if (cmd_out !== 3'd7) begin
                nop_bad++;
            end
            if (bg_out !== v.bg || ba_out !== v.ba || row_out !== v.row || col_out !== v.col)
                fld_bad++;
            if (wd_seen && v.write && wdata_out !== wd) wd_bad++;
            if (hold) begin
                req_addr_in  = {$urandom, $urandom};
                req_write_in = 1'($urandom);
            end
            if (req_ready_out) begin
                rdy_k = c;
                req_valid_in = 1'b0;
                break;
            end
        end
        req_valid_in = 1'b0;

        chk("precharge_cycle", 64'(pre_k), 64'(v.pre_k));
        chk("activate_cycle", 64'(act_k), 64'(v.act_k));
        chk("column_cycle", 64'(col_k), 64'(v.col_k));
        chk("column_cmd", 64'(col_cmd), {63'd0, v.write});
        chk("ready_return_cycle", 64'(rdy_k), 64'(v.rdy_k));
        chk("command_count", 64'(ncmd), 64'((v.pre_k != 0) + (v.act_k != 0) + 1));
        chk("nop_when_idle", 64'(nop_bad), 64'd0);
        chk("addr_fields_held", 64'(fld_bad), 64'd0);
        chk("row_hits", 64'(row_hits_out), 64'(v.hits));
        chk("row_conflicts", 64'(row_conflicts_out), 64'(v.conf));
        if (v.write) begin
            checks++;
            if (wd !== make_data(v.seed)) begin
                errors++;
                $display("FAIL wdata_at_write actual=%0h required=%0h", wd[127:0], make_data(v.seed) >> 0);
            end
            chk("wdata_stable", 64'(wd_bad), 64'd0);
        end
        $display("req addr=%h wr=%0d hold=%0d pre@%0d act@%0d col@%0d ready@%0d hits=%0d conflicts=%0d",
                 v.addr, v.write, hold, pre_k, act_k, col_k, rdy_k, row_hits_out, row_conflicts_out);
    endtask

    vec_t hv;

    initial begin
        //            addr                    wr    seed         bg    ba    row    col   pre act col rdy h  c
        vecs[0] = '{64'h0000_0000_0000_0123, 1'b0, 64'h0,     2'd1, 1'b0, 8'd2,  4'd3, 0, 1, 9,  17, 0, 0};
        vecs[1] = '{64'h0000_0000_0000_0123, 1'b0, 64'h0,     2'd1, 1'b0, 8'd2,  4'd3, 0, 0, 1,  9,  1, 0};
        vecs[2] = '{64'h0000_0000_0000_0523, 1'b0, 64'h0,     2'd1, 1'b0, 8'd10, 4'd3, 1, 6, 14, 22, 1, 1};
        vecs[3] = '{64'h0000_0000_0000_0133, 1'b1, 64'h11,    2'd1, 1'b1, 8'd2,  4'd3, 0, 1, 9,  17, 1, 1};
        vecs[4] = '{64'h0000_0000_0000_0133, 1'b0, 64'h0,     2'd1, 1'b1, 8'd2,  4'd3, 0, 0, 1,  9,  2, 1};
        vecs[5] = '{64'h0000_0000_0000_0533, 1'b1, 64'h0101,  2'd1, 1'b1, 8'd10, 4'd3, 1, 6, 14, 22, 2, 2};
        vecs[6] = '{64'hFFFF_0000_0000_0123, 1'b0, 64'h0,     2'd1, 1'b0, 8'd2,  4'd3, 1, 6, 14, 22, 2, 3};

        rst_in       = 1'b1;
        req_valid_in = 1'b0;
        req_addr_in  = '0;
        req_write_in = 1'b0;
        req_data_in  = '0;
        repeat (2) @(negedge clk_in);
        chk("reset_ready", 64'(req_ready_out), 64'd0);
        chk("reset_cmd_valid", 64'(cmd_valid_out), 64'd0);
        chk("reset_cmd", 64'(cmd_out), 64'd7);
        chk("reset_hits", 64'(row_hits_out), 64'd0);
        chk("reset_conflicts", 64'(row_conflicts_out), 64'd0);
        chk("reset_wdata_zero", 64'(wdata_out != '0), 64'd0);
        rst_in = 1'b0;
        @(negedge clk_in);
        chk("ready_after_release", 64'(req_ready_out), 64'd1);

        for (int i = 0; i < 7; i++) run_req(vecs[i], 1'b0);

        // Valid held high with scrambled inputs: only the accepted request runs.
        hv = '{64'h0000_0000_0000_0523, 1'b0, 64'h0, 2'd1, 1'b0, 8'd10, 4'd3, 1, 6, 14, 22, 2, 4};
        run_req(hv, 1'b1);

        // Reset in WAIT_ACT: outputs clear at once and the bank table is forgotten.
        req_valid_in = 1'b1;
        req_addr_in  = 64'h0143;
        req_write_in = 1'b0;
        @(posedge clk_in);
        #1 req_valid_in = 1'b0;
        @(negedge clk_in);
        chk("midseq_activate", {61'd0, cmd_out}, 64'd2);
        repeat (2) @(negedge clk_in);
        rst_in = 1'b1;
        #1;
        chk("midrst_cmd_valid", 64'(cmd_valid_out), 64'd0);
        chk("midrst_cmd", 64'(cmd_out), 64'd7);
        chk("midrst_ready", 64'(req_ready_out), 64'd0);
        chk("midrst_bg", 64'(bg_out), 64'd0);
        chk("midrst_row", 64'(row_out), 64'd0);
        chk("midrst_hits", 64'(row_hits_out), 64'd0);
        chk("midrst_conflicts", 64'(row_conflicts_out), 64'd0);
        @(negedge clk_in);
        rst_in = 1'b0;
        @(negedge clk_in);
        chk("ready_after_midrst", 64'(req_ready_out), 64'd1);

        hv = '{64'h0000_0000_0000_0143, 1'b0, 64'h0, 2'd2, 1'b0, 8'd2, 4'd3, 0, 1, 9, 17, 0, 0};
        run_req(hv, 1'b0);
        hv = '{64'h0000_0000_0000_0123, 1'b0, 64'h0, 2'd1, 1'b0, 8'd2, 4'd3, 0, 1, 9, 17, 0, 0};
        run_req(hv, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
